// File: rtl/vqueue_2entry.sv
//------------------------------------------------------------------------------
// Module      : vqueue_2entry
// Description : Two-entry normal FIFO with valid/ready handshakes on both
//               ports. There is no combinational path from enq to deq.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vqueue_2entry #(
    parameter int NBITS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enq_val,
    output logic             enq_rdy,
    input  logic [NBITS-1:0] enq_msg,
    output logic             deq_val,
    input  logic             deq_rdy,
    output logic [NBITS-1:0] deq_msg,
    output logic [1:0]       count
);

    localparam logic [1:0] C_EMPTY = 2'd0;
    localparam logic [1:0] C_FULL  = 2'd2;

    logic [NBITS-1:0] entry_q [2];
    logic [NBITS-1:0] entry_d [2];
    logic             head_q;
    logic             head_d;
    logic             tail_q;
    logic             tail_d;
    logic [1:0]       count_q;
    logic [1:0]       count_d;

    logic             w_enq_fire;
    logic             w_deq_fire;

    // Readiness depends only on registered occupancy, never on deq_rdy.
    assign enq_rdy    = !reset && (count_q != C_FULL);
    assign deq_val    = !reset && (count_q != C_EMPTY);
    assign deq_msg    = deq_val ? entry_q[head_q] : '0;
    assign count      = count_q;

    assign w_enq_fire = enq_val && enq_rdy;
    assign w_deq_fire = deq_val && deq_rdy;

    always_comb begin
        entry_d[0] = entry_q[0];
        entry_d[1] = entry_q[1];
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        if (w_enq_fire) begin
            entry_d[tail_q] = enq_msg;
            tail_d          = ~tail_q;
        end
        if (w_deq_fire) begin
            head_d = ~head_q;
        end

        case ({w_enq_fire, w_deq_fire})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            entry_q[0] <= '0;
            entry_q[1] <= '0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            count_q    <= C_EMPTY;
        end else begin
            entry_q[0] <= entry_d[0];
            entry_q[1] <= entry_d[1];
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

`ifndef SYNTHESIS
    a_count_max : assert property (@(posedge clk) count_q <= C_FULL);
    a_ptr_parity : assert property (@(posedge clk)
        (tail_q ^ head_q) == count_q[0]);
    a_full_ptrs : assert property (@(posedge clk)
        (count_q == C_FULL) |-> (head_q == tail_q));
    a_deq_stable : assert property (@(posedge clk) disable iff (reset)
        (deq_val && !deq_rdy) |=> $stable(deq_msg));
`endif

endmodule

`default_nettype wire

// File: doc/vqueue_2entry.md
Name: vqueue_2entry

Overview:
- Two-entry normal (non-bypass, non-pipe) FIFO with valid/ready handshakes on both sides.
- Sits directly upstream of the 32-bit capture register in the import test harness. Buffers a 32-bit message stream so the producer and consumer can stall independently.
- The dequeue side drives the register's d input.
- Exercises a real sequential handshake through the SystemVerilog import flow.

Parameters:
- NBITS, 32, message width in bits.
- Entry count is fixed at 2. It is not a parameter.

Ports:
- clk      input   1      clock; all state updates on posedge clk
- reset    input   1      synchronous active-high reset
- enq_val  input   1      producer has a valid message
- enq_rdy  output  1      queue can accept a message this cycle
- enq_msg  input   NBITS  message to enqueue
- deq_val  output  1      queue holds a message for the consumer
- deq_rdy  input   1      consumer accepts the message this cycle
- deq_msg  output  NBITS  head-of-queue message
- count    output  2      number of occupied entries, 0..2

Behaviour:
- Handshake definitions:
  - Enqueue transfer fires when enq_val && enq_rdy.
  - Dequeue transfer fires when deq_val && deq_rdy.
  - Transfers take effect at the posedge ending the cycle in which they fire.
- State:
  - Two NBITS storage entries.
  - 1-bit head pointer and 1-bit tail pointer; both wrap 1 -> 0.
  - 2-bit count register.
- Reset (reset high at a posedge):
  - count, head, tail and both entries are set to 0.
  - Reset overrides any transfer in the same cycle.
  - Reset asserted mid-operation discards all held messages.
- Combinational outputs:
  - enq_rdy = !reset && (count != 2).
  - deq_val = !reset && (count != 0).
  - deq_msg = entry[head] when deq_val is 1, else 0.
  - count port = count register.
- Latency and bypass rules:
  - Enqueue-to-dequeue latency is 1 cycle minimum. A message enqueued in cycle N is first visible on deq_msg/deq_val in cycle N+1.
  - No combinational enq -> deq path.
  - No deq_rdy -> enq_rdy path. When full, enq_rdy stays 0 even if deq_rdy is 1 that cycle.
- Per-cycle update, non-reset (E = enqueue fires, D = dequeue fires):
  - E only: entry[tail] <= enq_msg; tail <= tail+1; count <= count+1.
  - D only: head <= head+1; count <= count-1.
  - E and D (possible only at count==1): write entry[tail]; advance tail and head; count unchanged.
  - Neither: hold all state.
- Boundary conditions:
  - Empty (count 0): deq_rdy is ignored. deq_msg = 0.
  - Full (count 2): enq_val is ignored and enq_msg is not written.
  - Wrap-around: ordering is strictly FIFO across pointer wrap. Entry contents are overwritten only by a firing enqueue.
- Invariants (for assertions):
  - count never exceeds 2.
  - (tail - head) mod 2 == count mod 2.
  - At count 2, head == tail.
  - deq_msg stable while deq_val && !deq_rdy.
- Line trace, provided via the codebase's trace macros: "enq_msg(or blank) (count) deq_msg(or blank)", with messages printed in decimal.

Test Plan:
- Reset then idle: hold reset 2 cycles, release -> count=0, deq_val=0, enq_rdy=1, deq_msg=0. Also drive enq_val=1, enq_msg=5 during reset -> after reset count=0 (enqueue ignored).
- Single pass: enqueue 0x0000_00AA at cycle N with deq_rdy=0 -> cycle N+1 deq_val=1, deq_msg=0xAA, count=1. Then deq_rdy=1 -> next cycle count=0, deq_val=0.
- Fill and stall: enqueue 1, 2, 3 on consecutive cycles with deq_rdy=0 -> count=2 after the second, enq_rdy=0. Value 3 is not accepted while enq_rdy=0. deq_msg holds 1. Drain with deq_rdy=1 -> outputs 1 then 2. Producer re-offers 3 once enq_rdy=1 and it arrives next.
- Full with simultaneous deq: count=2, enq_val=1 (msg 9), deq_rdy=1 in the same cycle -> only the dequeue fires; count=1 next cycle; 9 is not stored.
- Steady streaming at count 1: enq_val=deq_rdy=1 every cycle with messages 10..20 -> count stays 1. deq_msg sequence is 10..20 delayed by one cycle with no gaps. Pointers wrap repeatedly with no loss or reordering.
- Reset mid-operation: with count=2 holding 7, 8, assert reset one cycle -> count=0, deq_val=0, deq_msg=0. Next enqueue of 4 emerges first, not 7.
